// File: rtl/clause_vote_accumulator.sv
// clause_vote_accumulator
//   Sums per-class clause votes with alternating polarity: even clause index
//   votes +1 and odd clause index votes -1. Each class sum is clamped to
//   [-THRESHOLD, +THRESHOLD] and the winning class is chosen by argmax, with
//   ties going to the lowest index. CHUNK clauses per class are consumed
//   each cycle. Valid/ready handshakes are used on both sides.
//
// Ports
//   clk             : clock, rising edge
//   rst_n           : asynchronous active-low reset
//   in_valid        : clause vector valid
//   in_ready        : block can accept a vector (IDLE, or DONE with out_ready)
//   in_clauses      : clause bits, class k at [k*NUM_CLAUSES +: NUM_CLAUSES]
//   out_valid       : result valid, held until out_ready
//   out_ready       : downstream accepts the result
//   class_sums      : clamped signed sums, class k at [k*SW +: SW]
//   predicted_class : argmax class index
module clause_vote_accumulator #(
    parameter int NUM_CLASSES = 2,
    parameter int NUM_CLAUSES = 10,
    parameter int CHUNK       = 2,
    parameter int THRESHOLD   = 15,
    // Derived widths; leave at their defaults.
    parameter int SW          = $clog2(NUM_CLAUSES) + 2,
    parameter int PW          = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_CLASSES*NUM_CLAUSES-1:0] in_clauses,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_CLASSES*SW-1:0]          class_sums,
    output logic [PW-1:0]                      predicted_class
);

    localparam int NUM_CHUNKS = NUM_CLAUSES / CHUNK;
    localparam int CW         = $clog2(NUM_CHUNKS + 1);
    localparam int VW         = NUM_CLASSES * NUM_CLAUSES;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        CALC,
        DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [VW-1:0]               clauses_q, clauses_d;
    logic signed [SW-1:0]        acc_q [NUM_CLASSES];
    logic signed [SW-1:0]        acc_d [NUM_CLASSES];
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [NUM_CLASSES*SW-1:0]   sums_q, sums_d;
    logic [PW-1:0]               pred_q, pred_d;
    logic                        ov_q, ov_d;

    logic                        accept;
    int                          vote    [NUM_CLASSES];
    int                          clamped [NUM_CLASSES];
    int                          best_val;
    int unsigned                 best_idx;

    assign in_ready        = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept          = in_valid && in_ready;
    assign out_valid       = ov_q;
    assign class_sums      = sums_q;
    assign predicted_class = pred_q;

    // Signed vote of the current chunk for every class. The class slice is
    // shifted down to the chunk base so no out-of-range index is formed.
    always_comb begin
        logic [NUM_CLAUSES-1:0] win;
        int unsigned            base;
        base = int'(cnt_q) * CHUNK;
        win  = '0;
        for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            vote[k] = 0;
            win     = clauses_q[k*NUM_CLAUSES +: NUM_CLAUSES] >> base;
            for (int unsigned c = 0; c < CHUNK; c++) begin
                if (((win >> c) & NUM_CLAUSES'(1)) != '0) begin
                    vote[k] += (((base + c) % 2) == 0) ? 1 : -1;
                end
            end
        end
    end

    // Signed clamp, then argmax with strict compare so ties keep the lower index.
    always_comb begin
        best_val = 0;
        best_idx = 0;
        for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            clamped[k] = int'(acc_q[k]);
            if (clamped[k] > THRESHOLD) begin
                clamped[k] = THRESHOLD;
            end else if (clamped[k] < -THRESHOLD) begin
                clamped[k] = -THRESHOLD;
            end
        end
        best_val = clamped[0];
        for (int unsigned k = 1; k < NUM_CLASSES; k++) begin
            if (clamped[k] > best_val) begin
                best_val = clamped[k];
                best_idx = k;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clauses_d = clauses_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sums_d    = sums_q;
        pred_d    = pred_q;
        ov_d      = ov_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                    acc_d[k] = acc_q[k] + SW'(vote[k]);
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NUM_CHUNKS - 1)) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                    sums_d[k*SW +: SW] = SW'(clamped[k]);
                end
                pred_d  = PW'(best_idx);
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = accept ? ACCUM : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // accept is only possible in IDLE or DONE, so this never collides
        // with the ACCUM accumulator/counter updates above.
        if (accept) begin
            clauses_d = in_clauses;
            cnt_d     = '0;
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                acc_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clauses_q <= '0;
            cnt_q     <= '0;
            sums_q    <= '0;
            pred_q    <= '0;
            ov_q      <= 1'b0;
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clauses_q <= clauses_d;
            cnt_q     <= cnt_d;
            sums_q    <= sums_d;
            pred_q    <= pred_d;
            ov_q      <= ov_d;
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

endmodule

// File: tb/tb_clause_vote_accumulator.sv
// tb_clause_vote_accumulator
//   Directed bench for clause_vote_accumulator. Two instances share all
//   inputs: dut (THRESHOLD=15) and dut3 (THRESHOLD=3) so clamp behaviour is
//   observed alongside the unclamped sums. Expected values are hand-computed
//   with SW=6: +5=6'h05, +3=6'h03, +1=6'h01, -3=6'h3D, -5=6'h3B.
module tb_clause_vote_accumulator;

    localparam int W  = 20;
    localparam int OW = 12;

    // class1 in [19:10], class0 in [9:0]
    localparam logic [W-1:0] V_POS  = {10'h000, 10'h155};
    localparam logic [W-1:0] V_NEG  = {10'h001, 10'h2AA};
    localparam logic [W-1:0] V_TIE  = {10'h155, 10'h155};
    localparam logic [W-1:0] V_ODD  = {10'h000, 10'h2AA};
    localparam logic [W-1:0] V_ONES = {10'h3FF, 10'h3FF};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_clauses = '0;

    logic          in_ready, out_valid;
    logic [OW-1:0] class_sums;
    logic [0:0]    predicted_class;
    logic          in_ready3, out_valid3;
    logic [OW-1:0] class_sums3;
    logic [0:0]    predicted_class3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clause_vote_accumulator #(
        .NUM_CLASSES(2), .NUM_CLAUSES(10), .CHUNK(2), .THRESHOLD(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_clauses(in_clauses), .out_valid(out_valid), .out_ready(out_ready),
        .class_sums(class_sums), .predicted_class(predicted_class)
    );

    clause_vote_accumulator #(
        .NUM_CLASSES(2), .NUM_CLAUSES(10), .CHUNK(2), .THRESHOLD(3)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
        .in_clauses(in_clauses), .out_valid(out_valid3), .out_ready(out_ready),
        .class_sums(class_sums3), .predicted_class(predicted_class3)
    );

    // Stimulus driver only: accepts one vector and counts cycles to out_valid.
    task automatic send_vec(input logic [W-1:0] v, output int lat, output bit busy_seen);
        int guard;
        guard      = 0;
        in_clauses = v;
        in_valid   = 1'b1;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_clauses = ~v;
        lat        = -1;
        busy_seen  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (in_ready) busy_seen = 1'b1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        n_cmp++;
        if (class_sums !== 12'h000) begin n_err++; $display("FAIL rst_sums: got %h want 000", class_sums); end
        n_cmp++;
        if (predicted_class !== 1'b0) begin n_err++; $display("FAIL rst_pred: got %0d want 0", predicted_class); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_positive();
        int lat; bit busy;
        send_vec(V_POS, lat, busy);
        n_cmp++;
        if (lat !== 6) begin n_err++; $display("FAIL pos_latency: got %0d want 6", lat); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL pos_in_ready_busy: got %0b want 0", busy); end
        n_cmp++;
        if (class_sums !== 12'h005) begin n_err++; $display("FAIL pos_sums: got %h want 005", class_sums); end
        n_cmp++;
        if (predicted_class !== 1'b0) begin n_err++; $display("FAIL pos_pred: got %0d want 0", predicted_class); end
        n_cmp++;
        if (class_sums3 !== 12'h003) begin n_err++; $display("FAIL pos_sums_t3: got %h want 003", class_sums3); end
        drain();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL pos_release: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
        end
        n_cmp++;
        if (class_sums !== 12'h005) begin n_err++; $display("FAIL pos_sums_held: got %h want 005", class_sums); end
    endtask

    task automatic test_negative();
        int lat; bit busy;
        send_vec(V_NEG, lat, busy);
        n_cmp++;
        if (lat !== 6) begin n_err++; $display("FAIL neg_latency: got %0d want 6", lat); end
        n_cmp++;
        if (class_sums !== 12'h07B) begin n_err++; $display("FAIL neg_sums: got %h want 07b", class_sums); end
        n_cmp++;
        if (predicted_class !== 1'b1) begin n_err++; $display("FAIL neg_pred: got %0d want 1", predicted_class); end
        n_cmp++;
        if (class_sums3 !== 12'h07D || predicted_class3 !== 1'b1) begin
            n_err++; $display("FAIL neg_t3: sums=%h pred=%0d want 07d/1", class_sums3, predicted_class3);
        end
        drain();
    endtask

    task automatic test_clamp_tie();
        int lat; bit busy;
        send_vec(V_TIE, lat, busy);
        n_cmp++;
        if (class_sums3 !== 12'h0C3) begin n_err++; $display("FAIL tie_sums_t3: got %h want 0c3", class_sums3); end
        n_cmp++;
        if (predicted_class3 !== 1'b0) begin n_err++; $display("FAIL tie_pred_t3: got %0d want 0", predicted_class3); end
        n_cmp++;
        if (class_sums !== 12'h145 || predicted_class !== 1'b0) begin
            n_err++; $display("FAIL tie_t15: sums=%h pred=%0d want 145/0", class_sums, predicted_class);
        end
        drain();
    endtask

    task automatic test_clamp_neg();
        int lat; bit busy;
        send_vec(V_ODD, lat, busy);
        n_cmp++;
        if (class_sums3 !== 12'h03D) begin n_err++; $display("FAIL clampneg_sums_t3: got %h want 03d", class_sums3); end
        n_cmp++;
        if (class_sums !== 12'h03B) begin n_err++; $display("FAIL clampneg_sums_t15: got %h want 03b", class_sums); end
        n_cmp++;
        if (predicted_class !== 1'b1 || predicted_class3 !== 1'b1) begin
            n_err++; $display("FAIL clampneg_pred: got %0d/%0d want 1/1", predicted_class, predicted_class3);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int lat; bit busy; bit unstable; int lat2;
        send_vec(V_POS, lat, busy);
        n_cmp++;
        if (lat !== 6) begin n_err++; $display("FAIL bp_latency: got %0d want 6", lat); end
        unstable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || class_sums !== 12'h005 || predicted_class !== 1'b0 || in_ready !== 1'b0)
                unstable = 1'b1;
        end
        n_cmp++;
        if (unstable !== 1'b0) begin n_err++; $display("FAIL bp_hold: outputs moved got %0b want 0", unstable); end
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_clauses = V_NEG;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %0b want 1", in_ready); end
        @(posedge clk); #1;
        out_ready  = 1'b0;
        in_valid   = 1'b0;
        in_clauses = '0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_after_accept: out_valid=%0b in_ready=%0b want 0/0", out_valid, in_ready);
        end
        lat2 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat2 = i; break; end
        end
        n_cmp++;
        if (lat2 !== 6) begin n_err++; $display("FAIL b2b_latency: got %0d want 6", lat2); end
        n_cmp++;
        if (class_sums !== 12'h07B || predicted_class !== 1'b1) begin
            n_err++; $display("FAIL b2b_result: sums=%h pred=%0d want 07b/1", class_sums, predicted_class);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int lat; bit busy; bit stale;
        in_clauses = V_ONES;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_valid3 !== 1'b0) begin
            n_err++; $display("FAIL midrst_out_valid: got %0b/%0b want 0/0", out_valid, out_valid3);
        end
        n_cmp++;
        if (class_sums !== 12'h000 || class_sums3 !== 12'h000) begin
            n_err++; $display("FAIL midrst_sums: got %h/%h want 000/000", class_sums, class_sums3);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
        stale = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        n_cmp++;
        if (stale !== 1'b0) begin n_err++; $display("FAIL midrst_stale: got %0b want 0", stale); end
        send_vec(V_POS, lat, busy);
        n_cmp++;
        if (lat !== 6 || class_sums !== 12'h005 || predicted_class !== 1'b0) begin
            n_err++; $display("FAIL midrst_fresh: lat=%0d sums=%h pred=%0d want 6/005/0", lat, class_sums, predicted_class);
        end
        drain();
    endtask

    task automatic test_all_ones();
        int lat; bit busy;
        send_vec(V_ONES, lat, busy);
        n_cmp++;
        if (lat !== 6) begin n_err++; $display("FAIL ones_latency: got %0d want 6", lat); end
        n_cmp++;
        if (class_sums !== 12'h000 || class_sums3 !== 12'h000) begin
            n_err++; $display("FAIL ones_sums: got %h/%h want 000/000", class_sums, class_sums3);
        end
        n_cmp++;
        if (predicted_class !== 1'b0) begin n_err++; $display("FAIL ones_pred: got %0d want 0", predicted_class); end
        drain();
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative();
        test_clamp_tie();
        test_clamp_neg();
        test_back_to_back();
        test_reset_mid();
        test_all_ones();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/clause_vote_accumulator.md
Name: clause_vote_accumulator

Overview:
- Downstream of the per-clause evaluation stage; consumes a captured vector of clause outputs for every class.
- Sums clause votes per class with alternating polarity: even clause index votes +1, odd clause index votes -1.
- Clamps each class sum to [-THRESHOLD, +THRESHOLD] and selects the winning class by argmax.
- Processes CHUNK clauses per class per cycle. Uses valid/ready handshakes on both sides.

Parameters:
- NUM_CLASSES, 2: number of classes.
- NUM_CLAUSES, 10: clauses per class. Must be even and a multiple of CHUNK.
- CHUNK, 2: clauses consumed per class per cycle.
- THRESHOLD, 15: clamp bound T, with T ≥ 1.
- SW, $clog2(NUM_CLAUSES)+2: signed sum width (derived; do not override).

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: clause vector valid.
- in_ready, output, 1: block can accept a vector.
- in_clauses, input, NUM_CLASSES*NUM_CLAUSES: clause bits. Class k occupies [k*NUM_CLAUSES +: NUM_CLAUSES]; bit j within it is clause j.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- class_sums, output, NUM_CLASSES*SW: clamped signed sums. Class k occupies [k*SW +: SW].
- predicted_class, output, $clog2(NUM_CLASSES) (minimum 1 bit): argmax index.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - out_valid=0, class_sums=0, predicted_class=0.
  - Accumulators and chunk counter are 0.
  - in_ready=1 in the first cycle after release.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_clauses into an internal register, clear accumulators and counter, go to ACCUM.
  - ACCUM: in_ready=0. Each cycle, for every class, add the signed vote of the CHUNK clauses at indices counter*CHUNK .. counter*CHUNK+CHUNK-1, then increment counter. After the last chunk (counter = NUM_CLAUSES/CHUNK-1), go to CALC.
  - CALC, one cycle:
    - Clamp each sum: above T becomes T; below -T becomes -T.
    - Register class_sums.
    - Compute argmax on the clamped sums. Ties go to the lowest index.
    - Register predicted_class, set out_valid=1, go to DONE.
  - DONE: out_valid=1. Outputs are held stable while out_ready=0.
    - On out_ready=1: out_valid falls next cycle.
    - If in_valid is also 1 in that cycle, in_ready=1 (in_ready = IDLE || (DONE && out_ready)). The new vector is captured and the block goes directly to ACCUM, which gives back-to-back operation.
    - Otherwise go to IDLE.
- Latency: a vector accepted at edge t produces out_valid=1 at edge t+NUM_CLAUSES/CHUNK+1 (edge t+6 with default parameters). Throughput is one vector per NUM_CLAUSES/CHUNK+2 cycles.
- Arithmetic:
  - Accumulators are signed, SW bits wide. The unclamped range is ±NUM_CLAUSES/2, so no overflow is possible.
  - The clamp comparison is signed.
  - class_sums keeps its value after out_valid falls and is updated only in CALC.
- in_clauses is sampled only on the accept edge. Changes outside that edge have no effect.
- in_valid while busy is ignored (no accept). The upstream must hold it.
- An rst_n assertion in any state (mid-ACCUM or DONE) immediately forces the reset values. The partial result is discarded and nothing is emitted.

Test Plan:
- Positive sum, class 0: class0 bits 0,2,4,6,8 = 1, class1 all 0. Accept at edge t → out_valid rises at edge t+6 with class_sums = {class1=0, class0=+5}, predicted_class=0, in_ready=0 during edges t+1..t+6.
- Negative sum, class 1 wins: class0 bits 1,3,5,7,9 = 1, class1 bit 0 = 1 → class0=-5, class1=+1, predicted_class=1.
- Clamp and tie:
  - THRESHOLD=3: class0 = all even bits, class1 = all even bits → both sums clamp to +3, tie gives predicted_class=0.
  - THRESHOLD=3, class0 = all odd bits → sum -3.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 and a new vector → accepted in the same cycle, next result arrives 6 cycles later.
- Reset mid-operation: assert rst_n=0 two cycles into ACCUM → out_valid=0, sums=0 immediately. After release, in_ready=1, no stale result is emitted, and a fresh vector gives the correct result.
- All ones: every bit set in both classes → sums 0,0, predicted_class=0.
